// File: rtl/pr_peak_phase.sv
// pr_peak_phase: channel-0 peak search with per-channel relative phase capture and result sequencer
module pr_peak_phase #(
    parameter int NSINK   = 3,
    parameter int MWIDTH  = 25,
    parameter int FFT     = 11,
    parameter int BIN_LO  = 1,
    parameter int BIN_HI  = 1023,
    parameter int BIN_HZ  = 9766,
    parameter int MAG_MIN = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sink_valid,
    input  logic              sink_sop,
    input  logic              sink_eop,
    input  logic [MWIDTH-1:0] sink_mag,
    input  logic [15:0]       sink_phase,
    output logic              source_valid,
    output logic              source_sop,
    output logic              source_eop,
    output logic [2:0]        source_chan,
    output logic [23:0]       source_freq,
    output logic [MWIDTH-1:0] source_mag,
    output logic [15:0]       source_phase,
    output logic              source_found,
    output logic              error
);
    localparam int CW = $clog2(NSINK);
    localparam logic [FFT-1:0] LO = FFT'(BIN_LO);
    localparam logic [FFT-1:0] HI = FFT'(BIN_HI);
    localparam logic [FFT-1:0] LAST = '1;
    localparam logic [CW-1:0] LAST_CH = CW'(NSINK - 1);
    localparam logic [MWIDTH-1:0] MMIN = MWIDTH'(MAG_MIN);
    typedef enum logic [1:0] {IDLE, SEARCH, CAPTURE} state_t;
    state_t state_q, state_d;
    logic [FFT-1:0] bin_q, bin_d, cur_bin, best_bin_q, best_bin_d;
    logic [CW-1:0] chan_q, chan_d, seq_q, seq_d;
    logic [MWIDTH-1:0] best_mag_q, best_mag_d, out_mag_q, out_mag_d;
    logic [15:0] ref_q, ref_d;
    logic [15:0] slot_q [NSINK];
    logic [15:0] slot_d [NSINK];
    logic [15:0] out_slot_q [NSINK];
    logic [15:0] out_slot_d [NSINK];
    logic [23:0] out_freq_q, out_freq_d;
    logic out_found_q, out_found_d, error_q, error_d;
    logic err, start, do_search, do_capture, in_win;
    logic signed [16:0] diff, wrapped;
    always_comb begin
        cur_bin = sink_sop ? '0 : bin_q;
        bin_d = sink_valid ? cur_bin + 1'b1 : bin_q;
        // an eop must land exactly on the last bin, and the last bin must carry eop
        err = sink_valid && state_q != IDLE && ((sink_sop && bin_q != '0) || (sink_eop != (cur_bin == LAST)));
        start = sink_valid && sink_sop && (state_q == IDLE || err);
        do_search = start || (sink_valid && state_q == SEARCH && !err);
        do_capture = sink_valid && state_q == CAPTURE && !err;
        in_win = cur_bin >= LO && cur_bin <= HI;
        diff = {sink_phase[15], sink_phase} - {ref_q[15], ref_q};
        wrapped = diff > 17'sd25736 ? diff - 17'sd51472 : diff < -17'sd25736 ? diff + 17'sd51472 : diff;
        state_d = state_q;
        chan_d = chan_q;
        best_mag_d = start ? '0 : best_mag_q;
        best_bin_d = start ? LO : best_bin_q;
        ref_d = ref_q;
        slot_d = slot_q;
        out_slot_d = out_slot_q;
        out_mag_d = out_mag_q;
        out_freq_d = out_freq_q;
        out_found_d = out_found_q;
        error_d = err;
        seq_d = (seq_q == '0 || seq_q == LAST_CH) ? '0 : seq_q + 1'b1;
        if (do_search && in_win && (sink_mag > best_mag_d || cur_bin == LO)) begin
            best_mag_d = sink_mag;
            best_bin_d = cur_bin;
            ref_d = sink_phase;
        end
        if (do_capture && cur_bin == best_bin_q)
            slot_d[chan_q] = wrapped[15:0];
        if (err)
            state_d = IDLE;
        if (start) begin
            state_d = SEARCH;
            chan_d = '0;
        end else if (do_search && sink_eop) begin
            state_d = CAPTURE;
            chan_d = CW'(1);
        end else if (do_capture && sink_eop) begin
            chan_d = chan_q + 1'b1;
            if (chan_q == LAST_CH) begin
                state_d = IDLE;
                chan_d = '0;
                out_slot_d = slot_d;
                out_mag_d = best_mag_q;
                out_freq_d = 24'(32'(best_bin_q) * BIN_HZ);
                out_found_d = $signed({1'b0, best_mag_q}) >= $signed({1'b0, MMIN});
                seq_d = CW'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q <= '0;
            chan_q <= '0;
            seq_q <= '0;
            best_bin_q <= '0;
            best_mag_q <= '0;
            ref_q <= '0;
            slot_q <= '{default: '0};
            out_slot_q <= '{default: '0};
            out_mag_q <= '0;
            out_freq_q <= '0;
            out_found_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q <= bin_d;
            chan_q <= chan_d;
            seq_q <= seq_d;
            best_bin_q <= best_bin_d;
            best_mag_q <= best_mag_d;
            ref_q <= ref_d;
            slot_q <= slot_d;
            out_slot_q <= out_slot_d;
            out_mag_q <= out_mag_d;
            out_freq_q <= out_freq_d;
            out_found_q <= out_found_d;
            error_q <= error_d;
        end
    end
    assign source_valid = seq_q != '0;
    assign source_sop = seq_q == CW'(1);
    assign source_eop = seq_q == LAST_CH;
    assign source_chan = 3'(seq_q);
    assign source_freq = source_valid ? out_freq_q : '0;
    assign source_mag = source_valid ? out_mag_q : '0;
    assign source_phase = source_valid ? out_slot_q[seq_q] : '0;
    assign source_found = source_valid && out_found_q;
    assign error = error_q;
endmodule
